// File: rtl/cmd_scheduler.sv
// Time-triggered command scheduler: pops a command word from the FIFO, holds it
// until global_clock reaches its start time, then offers it with ack timeout.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for enable and a non-empty FIFO
// S_POP   | single-cycle FIFO read strobe
// S_LOAD  | capture FIFO word into command registers
// S_WAIT  | hold until global_clock >= start_time (late check on 1st cycle)
// S_ISSUE | cmd_valid asserted, waiting for cmd_ack or timeout
module cmd_scheduler #(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [31:0] global_clock,
   input  logic [79:0] cmd_fifo_dout,
   input  logic        cmd_fifo_empty,
   output logic        cmd_fifo_rd_en,
   output logic [7:0]  cmd_addr,
   output logic [7:0]  cmd_opcode,
   output logic [31:0] cmd_data,
   output logic        cmd_valid,
   input  logic        cmd_ack,
   output logic        busy,
   output logic [15:0] late_count,
   output logic [15:0] timeout_count
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_POP   = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_ISSUE = 3'd4;

   // Drop happens in the cycle the counter would reach ACK_TIMEOUT, so
   // cmd_valid stays up for exactly ACK_TIMEOUT cycles.
   localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT - 1);

   logic [2:0]  state;
   logic [31:0] start_time;
   logic        first_wait;
   logic [15:0] ack_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         cmd_addr      <= 8'd0;
         cmd_opcode    <= 8'd0;
         cmd_data      <= 32'd0;
         start_time    <= 32'd0;
         first_wait    <= 1'b0;
         ack_cnt       <= 16'd0;
         late_count    <= 16'd0;
         timeout_count <= 16'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (enable && !cmd_fifo_empty)
                  state <= S_POP;
            end
            S_POP: begin
               state <= S_LOAD;
            end
            S_LOAD: begin
               cmd_addr   <= cmd_fifo_dout[79:72];
               cmd_opcode <= cmd_fifo_dout[71:64];
               start_time <= cmd_fifo_dout[63:32];
               cmd_data   <= cmd_fifo_dout[31:0];
               first_wait <= 1'b1;
               state      <= S_WAIT;
            end
            S_WAIT: begin
               first_wait <= 1'b0;
               if (first_wait && (global_clock > start_time) && (late_count != 16'hFFFF))
                  late_count <= late_count + 16'd1;
               if (global_clock >= start_time) begin
                  ack_cnt <= 16'd0;
                  state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (cmd_ack) begin
                  state <= S_IDLE;
               end else begin
                  ack_cnt <= ack_cnt + 16'd1;
                  if (ack_cnt == ACK_LAST) begin
                     state <= S_IDLE;
                     if (timeout_count != 16'hFFFF)
                        timeout_count <= timeout_count + 16'd1;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_fifo_rd_en = (state == S_POP);
   assign cmd_valid      = (state == S_ISSUE);
   assign busy           = (state != S_IDLE);

endmodule
